// File: rtl/spi_byte_rx.sv
// -----------------------------------------------------------------------------
// spi_byte_rx
//
// SPI slave byte receiver, mode 0, chip select active-low. The SCK, MOSI and CS
// pins are brought into the i_clk domain through equal-depth synchronizers.
// Rising SCK edges are detected in the i_clk domain, and whole bytes are
// assembled from them. Each completed byte is presented on o_data together with
// a single-cycle o_valid strobe. o_first marks the first byte of a CS frame.
//
// Optional feature (compile-time macro):
//   SPI_BYTE_RX_FRAME_ERR_EN - when defined, o_frame_err pulses for one cycle
//                              when CS rises in the middle of a byte. When
//                              undefined, o_frame_err is tied to 0 and
//                              truncated bytes are dropped silently.
//
// Parameters:
//   SYNC_STAGES - flip-flop depth of each pin synchronizer (>= 2)
//   MSB_FIRST   - 1: the first bit on the wire is bit 7; 0: it is bit 0
//
// Ports:
//   i_clk       - system clock, the only clock in this block
//   i_rst       - asynchronous, active-high reset
//   i_sck       - SPI clock pin (asynchronous)
//   i_mosi      - SPI data pin (asynchronous)
//   i_cs        - SPI chip select pin, active-low (asynchronous)
//   o_data      - last completed byte; held until the next byte completes
//   o_valid     - one-cycle strobe, high when o_data updates
//   o_first     - qualifies o_valid; high for the first byte of a CS frame
//   o_busy      - synchronized CS is active (a frame is in progress)
//   o_frame_err - one-cycle pulse when a frame is truncated (optional feature)
// -----------------------------------------------------------------------------
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sck,
    input  logic       i_mosi,
    input  logic       i_cs,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_first,
    output logic       o_busy,
    output logic       o_frame_err
);

    // -------------------------------------------------------------------------
    // Pin synchronizers. All three chains have the same depth, so a MOSI bit
    // arrives in step with the SCK edge that samples it, and CS stays aligned
    // with both.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_prev;

    logic sck_s;
    logic mosi_s;
    logic cs_s;
    logic sck_rise;

    // NOTE: Registers take non-blocking assignments. Every flop then samples
    // the values from before the clock edge, whatever order the statements
    // are in.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;   // CS resets to its idle (deselected) level
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  i_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   i_cs};
            sck_prev  <= sck_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;

    // A frame is in progress while the synchronized CS is low.
    assign o_busy = ~cs_s;

    // -------------------------------------------------------------------------
    // Byte assembly
    // -------------------------------------------------------------------------
    logic [2:0] cnt_q,        cnt_d;
    logic [7:0] shift_q,      shift_d;
    logic [7:0] data_d;
    logic       valid_d;
    logic       first_out_d;
    logic       first_flag_q, first_flag_d;
    logic [7:0] completed;

    // The shift register with the current MOSI bit already merged in. On the
    // eighth rising edge this value is the whole byte.
    always_comb begin
        if (MSB_FIRST) begin
            completed = {shift_q[6:0], mosi_s};
        end else begin
            completed = {mosi_s, shift_q[7:1]};
        end
    end

`ifdef SPI_BYTE_RX_FRAME_ERR_EN
    logic frame_err_d;
`endif

    // NOTE: Each output of this block gets a default value first. Every path
    // then assigns every signal, so no latch is inferred.
    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        data_d       = o_data;
        valid_d      = 1'b0;
        first_out_d  = 1'b0;
        first_flag_d = first_flag_q;
`ifdef SPI_BYTE_RX_FRAME_ERR_EN
        frame_err_d  = 1'b0;
`endif

        if (cs_s) begin
            // Idle. CS is tested before sck_rise, so a rising edge in the same
            // cycle as CS going high is discarded, and any partial byte is
            // dropped without a strobe.
            cnt_d        = 3'd0;
            shift_d      = 8'h00;
            first_flag_d = 1'b1;
`ifdef SPI_BYTE_RX_FRAME_ERR_EN
            frame_err_d  = (cnt_q != 3'd0);
`endif
        end else if (sck_rise) begin
            shift_d = completed;
            cnt_d   = cnt_q + 3'd1;   // wraps 7 -> 0 for back-to-back bytes
            if (cnt_q == 3'd7) begin
                data_d       = completed;
                valid_d      = 1'b1;
                first_out_d  = first_flag_q;
                first_flag_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q        <= 3'd0;
            shift_q      <= 8'h00;
            o_data       <= 8'h00;
            o_valid      <= 1'b0;
            o_first      <= 1'b0;
            first_flag_q <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            o_data       <= data_d;
            o_valid      <= valid_d;
            o_first      <= first_out_d;
            first_flag_q <= first_flag_d;
        end
    end

`ifdef SPI_BYTE_RX_FRAME_ERR_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= frame_err_d;
        end
    end
`else
    assign o_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_rx
//
// Self-checking bench for spi_byte_rx. Two instances share the SPI pins: one
// with MSB_FIRST=1 and one with MSB_FIRST=0. Expected bytes are pushed to one
// queue per instance as stimulus is driven. A monitor for each instance pops
// and compares an entry on every o_valid strobe.
// -----------------------------------------------------------------------------
module tb_spi_byte_rx;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst;
    logic sck;
    logic mosi;
    logic cs;

    logic [7:0] data_m, data_l;
    logic       valid_m, valid_l;
    logic       first_m, first_l;
    logic       busy_m, busy_l;
    logic       fe_m, fe_l;

    always #5 clk = ~clk;

    spi_byte_rx #(.SYNC_STAGES(SYNC), .MSB_FIRST(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_mosi(mosi), .i_cs(cs),
        .o_data(data_m), .o_valid(valid_m), .o_first(first_m),
        .o_busy(busy_m), .o_frame_err(fe_m)
    );

    spi_byte_rx #(.SYNC_STAGES(SYNC), .MSB_FIRST(1'b0)) dut_lsb (
        .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_mosi(mosi), .i_cs(cs),
        .o_data(data_l), .o_valid(valid_l), .o_first(first_l),
        .o_busy(busy_l), .o_frame_err(fe_l)
    );

    typedef struct {
        logic [7:0] data;
        logic       first;
    } exp_t;

    typedef struct {
        logic [7:0] wire_bits;   // transmitted bit 7 first
        logic       new_frame;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
        logic       exp_first;
    } vec_t;

    exp_t q_msb[$];
    exp_t q_lsb[$];

    int total = 0;
    int bad   = 0;
    int fe_seen_m = 0;
    int fe_seen_l = 0;
    int fe_exp    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------------------------------------------------------- monitors
    exp_t em, el;
    logic prev_vm = 1'b0;
    logic prev_vl = 1'b0;

    always @(negedge clk) begin
        if (valid_m) begin
            if (q_msb.size() == 0) begin
                fail_now("msb_unexpected_valid");
            end else begin
                em = q_msb.pop_front();
                check("msb_data", {24'b0, data_m}, {24'b0, em.data});
                check("msb_first", {31'b0, first_m}, {31'b0, em.first});
            end
            check("msb_valid_not_consecutive", {31'b0, prev_vm}, 32'd0);
        end
        if (fe_m) fe_seen_m++;
        prev_vm <= valid_m;
    end

    always @(negedge clk) begin
        if (valid_l) begin
            if (q_lsb.size() == 0) begin
                fail_now("lsb_unexpected_valid");
            end else begin
                el = q_lsb.pop_front();
                check("lsb_data", {24'b0, data_l}, {24'b0, el.data});
                check("lsb_first", {31'b0, first_l}, {31'b0, el.first});
            end
            check("lsb_valid_not_consecutive", {31'b0, prev_vl}, 32'd0);
        end
        if (fe_l) fe_seen_l++;
        prev_vl <= valid_l;
    end

    // --------------------------------------------------------------- stimulus
    task automatic send_bit(input logic b);
        @(negedge clk);
        mosi = b;
        repeat (2) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] w, input bit push,
                             input logic [7:0] e_msb, input logic [7:0] e_lsb,
                             input logic f);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && push) begin
                q_msb.push_back('{data: e_msb, first: f});
                q_lsb.push_back('{data: e_lsb, first: f});
            end
            send_bit(w[i]);
        end
    endtask

    task automatic open_frame();
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic close_frame();
        @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        logic [7:0] a5;
        bit frame_open;

        vecs[0] = '{8'h01, 1'b1, 8'h01, 8'h80, 1'b1};
        vecs[1] = '{8'h80, 1'b0, 8'h80, 8'h01, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 8'h80, 8'h01, 1'b1};   // 0x01 sent LSB-first
        vecs[4] = '{8'h12, 1'b1, 8'h12, 8'h48, 1'b1};
        vecs[5] = '{8'h5A, 1'b0, 8'h5A, 8'h5A, 1'b0};

        rst = 1'b1; sck = 1'b0; mosi = 1'b0; cs = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data", {24'b0, data_m}, 32'h00);
        check("rst_valid", {31'b0, valid_m}, 32'd0);
        check("rst_first", {31'b0, first_m}, 32'd0);
        check("rst_busy", {31'b0, busy_m}, 32'd0);
        check("rst_frame_err", {31'b0, fe_m}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Idle: SCK toggles with CS high; nothing may be received.
        for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (6) @(negedge clk);
        check("idle_data", {24'b0, data_m}, 32'h00);
        check("idle_busy", {31'b0, busy_m}, 32'd0);

        // Single 0xA5 frame, with the o_busy delay and the o_valid latency
        // checked cycle by cycle.
        a5 = 8'hA5;
        @(negedge clk);
        cs = 1'b0;
        @(posedge clk); #1;
        check("busy_delay_1", {31'b0, busy_m}, 32'd0);
        @(posedge clk); #1;
        check("busy_delay_2", {31'b0, busy_m}, 32'd1);
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 1; i--) send_bit(a5[i]);
        q_msb.push_back('{data: 8'hA5, first: 1'b1});
        q_lsb.push_back('{data: 8'hA5, first: 1'b1});
        @(negedge clk);
        mosi = a5[0];
        repeat (2) @(negedge clk);
        sck = 1'b1;
        for (int k = 1; k <= SYNC + 1; k++) begin
            @(posedge clk); #1;
            check($sformatf("a5_latency_edge%0d", k), {31'b0, valid_m},
                  (k == SYNC + 1) ? 32'd1 : 32'd0);
        end
        repeat (3) @(negedge clk);
        sck = 1'b0;
        close_frame();

        // Table-driven frames.
        frame_open = 1'b0;
        foreach (vecs[i]) begin
            if (vecs[i].new_frame) begin
                if (frame_open) close_frame();
                open_frame();
                frame_open = 1'b1;
            end
            send_byte(vecs[i].wire_bits, 1'b1, vecs[i].exp_msb, vecs[i].exp_lsb,
                      vecs[i].exp_first);
            check($sformatf("vec%0d_busy", i), {31'b0, busy_m}, 32'd1);
        end
        close_frame();
        check("table_busy_after", {31'b0, busy_m}, 32'd0);

        // Truncated frame: five bits, then CS rises.
        open_frame();
        for (int i = 7; i >= 3; i--) send_bit(1'(8'h3C >> i));
        close_frame();
`ifdef SPI_BYTE_RX_FRAME_ERR_EN
        fe_exp++;
`endif
        check("trunc_frame_err_count", fe_seen_m, fe_exp);
        check("trunc_data_held_msb", {24'b0, data_m}, 32'h5A);
        check("trunc_data_held_lsb", {24'b0, data_l}, 32'h5A);
        open_frame();
        send_byte(8'h3C, 1'b1, 8'h3C, 8'h3C, 1'b1);
        close_frame();

        // Reset in the middle of a byte, then a clean resend.
        open_frame();
        for (int i = 7; i >= 4; i--) send_bit(1'(8'h55 >> i));
        @(negedge clk); #2;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cs = 1'b1;
        check("midrst_data", {24'b0, data_m}, 32'h00);
        check("midrst_busy", {31'b0, busy_m}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        open_frame();
        send_byte(8'h55, 1'b1, 8'h55, 8'hAA, 1'b1);
        close_frame();

        // Drain any outstanding expectations within a bounded time.
        for (int i = 0; i < 100 && (q_msb.size() != 0 || q_lsb.size() != 0); i++)
            @(negedge clk);
        check("msb_queue_drained", q_msb.size(), 32'd0);
        check("lsb_queue_drained", q_lsb.size(), 32'd0);
        check("frame_err_total_msb", fe_seen_m, fe_exp);
        check("frame_err_total_lsb", fe_seen_l, fe_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_byte_rx.md
# spi_byte_rx

SPI slave byte receiver (mode 0, CS active-low) that brings the Raspberry Pi's SCK/MOSI/CS pins into the `i_clk` domain and assembles complete bytes. It sits directly upstream of the LED command decoder: each received byte is presented as `o_data` with a single-cycle `o_valid` strobe, plus framing flags. It is instantiated below the board top level and receives the already-inverted, active-high reset.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of each pin synchronizer (≥2).
- `MSB_FIRST`, default 1: 1 means the first bit of a frame is bit 7; 0 means it is bit 0.

Ports:
- `i_clk` in 1: system clock; only clock in the block.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_sck` in 1: SPI clock pin, asynchronous to `i_clk`.
- `i_mosi` in 1: SPI data pin, asynchronous.
- `i_cs` in 1: SPI chip select pin, active-low, asynchronous.
- `o_data` out 8: last completed byte; holds until the next byte completes.
- `o_valid` out 1: one-cycle strobe, asserted when `o_data` updates.
- `o_first` out 1: qualifies `o_valid`; high for the first byte of a CS frame.
- `o_busy` out 1: synchronized CS is active (frame in progress).
- `o_frame_err` out 1: one-cycle pulse on a truncated frame (see Configuration).

## Operation
- Synchronizers: `i_sck`, `i_mosi` and `i_cs` each pass through `SYNC_STAGES` flops. All three use equal depth so their relative alignment is preserved.
- Reset values of the synchronizers: sck=0, mosi=0, cs=1 (idle).
- Edge detect: one extra register holds the previous synchronized SCK. `sck_rise` = synced SCK high and previous SCK low.
- Idle state: synced CS high.
  - Bit counter (3 bits) held at 0, shift register cleared.
  - `o_busy`=0; the first-byte flag is set.
- Receive state: synced CS low, `o_busy`=1.
- On each `sck_rise`:
  - Synced MOSI is shifted in: into the LSB with left shift when `MSB_FIRST`=1, into the MSB with right shift when 0.
  - Bit counter increments and wraps from 7 to 0.
- On the `sck_rise` that takes the count from 7 to 0:
  - `o_data` is loaded with the completed byte (the 7 stored bits plus the current bit).
  - `o_valid`=1 for that cycle.
  - `o_first` = first-byte flag, which is then cleared.
- Back-to-back bytes within one frame need no gap; the counter simply continues.
- CS rising while the bit counter is non-zero: the partial byte is discarded, `o_data` is unchanged, and no `o_valid` is issued.
- Simultaneous `sck_rise` and synced CS high in the same cycle: CS wins. The bit is discarded and no byte completes.
- SCK edges while CS is high are ignored.
- Falling SCK edges are ignored; the master changes MOSI on them.

## Timing
- Reset (async assert, deassert sampled on `i_clk`): `o_data`=8'h00; `o_valid`, `o_first`, `o_busy`, `o_frame_err` = 0; bit counter = 0.
- Latency: `o_valid` is high in the cycle following SYNC_STAGES+1 `i_clk` rising edges, counted from the first edge that samples the 8th SCK high.
- `o_busy` follows `i_cs` falling/rising with SYNC_STAGES cycles of delay.
- Clock constraints:
  - `i_clk` ≥ 4× SCK frequency.
  - SCK high and low phases each ≥ 2 `i_clk` periods.
  - MOSI stable ≥ 2 `i_clk` periods around each SCK rise.
- `o_valid` is never high on two consecutive cycles. There is no back-pressure; the consumer must accept on the strobe.
- Reset asserted mid-byte aborts the byte immediately. No `o_valid` or `o_frame_err` is produced for it.

## Configuration
- Macro `SPI_BYTE_RX_FRAME_ERR_EN`.
- Defined: when synced CS rises with the bit counter ≠ 0, `o_frame_err`=1 for exactly one cycle, in the same cycle the partial byte is discarded.
- Undefined: `o_frame_err` is tied to 0 and truncated frames are discarded silently. All other behaviour is identical.

## Test plan
- Reset then idle: `i_cs`=1 with SCK toggling → all outputs stay 0, no `o_valid`.
- Single frame carrying 0xA5, `MSB_FIRST`=1 → exactly one `o_valid` with `o_data`=0xA5, `o_first`=1, at SYNC_STAGES+1 cycles after the 8th rise is sampled.
- One frame carrying 0x01, 0x80, 0xFF back-to-back → three `o_valid` strobes with those values; `o_first` pattern 1,0,0; `o_busy`=1 throughout.
- `MSB_FIRST`=0 with 0x01 sent LSB-first on the wire → `o_data`=0x01.
- CS raised after 5 bits, then a full 0x3C frame:
  - Macro defined: `o_frame_err` pulses once.
  - Both builds: no strobe for the partial byte; next byte 0x3C with `o_first`=1.
- Reset asserted after bit 4 of 0x55, then released and 0x55 resent → no output for the aborted byte; clean 0x55 with `o_first`=1.
